cfg_space_ctrl: RTL and testbench



---
 rtl/cfg_pkg.sv | 26 ++
 rtl/cfg_rr_arbiter.sv | 38 +++
 rtl/cfg_space_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_cfg_space_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared types and helpers for the configuration-space controller.
package cfg_pkg;

   // Controller states: one request is granted, executed and acknowledged per pass.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      ACCESS = 2'd2,
      ACK    = 2'd3
   } cfg_state_t;

   // Identity of the two requesters competing for the register file.
   typedef enum logic {
      REQ_APB = 1'b0,
      REQ_INT = 1'b1
   } req_id_t;

   // An all-zero strobe marks a full-word read.
   localparam logic [3:0] STRB_READ = 4'b0000;

   // Even parity bit: makes the total number of ones in {word, bit} even.
   function automatic logic even_parity(input logic [31:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/cfg_rr_arbiter.sv
// Two-way round-robin arbiter. After each completed grant the priority
// pointer moves to the side that did not win; a lone requester always wins.
module cfg_rr_arbiter
   import cfg_pkg::*;
(
   input  logic       S_CLK,
   input  logic       PRESETn_SYNC,
   input  logic [1:0] req,        // bit 0 = APB side, bit 1 = internal side
   input  logic       advance,    // one pulse per completed grant
   input  req_id_t    granted,    // side that completed the grant
   output logic [1:0] winner      // one-hot, bit order as req
);

   req_id_t prio_r;

   // Priority pointer: starts at APB, handed to the other side after each grant.
   always_ff @(posedge S_CLK or negedge PRESETn_SYNC) begin
      if (!PRESETn_SYNC) begin
         prio_r <= REQ_APB;
      end else if (advance) begin
         prio_r <= (granted == REQ_APB) ? REQ_INT : REQ_APB;
      end else begin
         prio_r <= prio_r;
      end
   end

   // Winner selection: contention resolved by the pointer, otherwise the lone requester.
   always_comb begin
      winner = 2'b00;
      case (req)
         2'b01:   winner = 2'b01;
         2'b10:   winner = 2'b10;
         2'b11:   winner = (prio_r == REQ_APB) ? 2'b01 : 2'b10;
         default: winner = 2'b00;
      endcase
   end

endmodule

// File: rtl/cfg_space_ctrl.sv
// Configuration-space controller: arbitrates APB and internal requesters,
// executes byte-strobed writes / full-word reads on a parity-protected
// register file and returns ACK, read data and sticky-until-next-ACK flags.
module cfg_space_ctrl
   import cfg_pkg::*;
#(
   parameter int                 DATA_WD  = 32,
   parameter int                 ADDR_WD  = 16,
   parameter int                 NUM_REGS = 64,
   parameter logic [DATA_WD-1:0] CFG_ID   = 32'h0A9B_0001
)(
   input  logic               S_CLK,
   input  logic               PRESETn_SYNC,
   input  logic               APB_Request,
   input  logic [ADDR_WD-1:0] APB_OADDR,
   input  logic [DATA_WD-1:0] APB_ODATA,
   input  logic [3:0]         APB_OSTRB,
   output logic               APB_Grant,
   output logic               ConfigSp_ACKAPB,
   input  logic               INT_Request,
   input  logic [ADDR_WD-1:0] INT_ADDR,
   input  logic [DATA_WD-1:0] INT_DATA,
   input  logic [3:0]         INT_STRB,
   output logic               INT_Grant,
   output logic               INT_ACK,
   output logic [DATA_WD-1:0] ConfigSp_DATA,
   output logic               Addr_ER,
   output logic               Parity_ER,
   input  logic               PAR_INJ
);

   localparam int IDX_WD  = $clog2(NUM_REGS);
   localparam int WIDX_WD = ADDR_WD - 2;

   // FSM and registered handshake outputs
   cfg_state_t state_r, state_nxt_s;
   req_id_t    winner_r, winner_nxt_s;
   logic       apb_grant_r, apb_grant_nxt_s;
   logic       int_grant_r, int_grant_nxt_s;
   logic       apb_ack_r, apb_ack_nxt_s;
   logic       int_ack_r, int_ack_nxt_s;
   logic [1:0] arb_win_s;
   logic       win_req_s;
   logic       capture_s;
   logic       advance_s;
   logic       execute_s;

   // Captured transaction
   logic [ADDR_WD-1:0] cap_addr_r;
   logic [DATA_WD-1:0] cap_data_r;
   logic [3:0]         cap_strb_r;
   logic               cap_inj_r;

   // Register file: data words plus one stored parity bit per word
   logic [DATA_WD-1:0]  mem_r [NUM_REGS];
   logic [NUM_REGS-1:0] par_r;

   // Decode / execute
   logic [WIDX_WD-1:0] word_s;
   logic [IDX_WD-1:0]  idx_s;
   logic               addr_err_s;
   logic               is_read_s;
   logic               is_word0_s;
   logic [DATA_WD-1:0] rd_word_s;
   logic               rd_par_s;
   logic [DATA_WD-1:0] merged_s;
   logic               wr_en_s;
   logic [DATA_WD-1:0] data_nxt_s;
   logic               aer_nxt_s;
   logic               per_nxt_s;

   // Result registers seen by both requesters
   logic [DATA_WD-1:0] data_r;
   logic               addr_er_r;
   logic               par_er_r;

   cfg_rr_arbiter u_arb (
      .S_CLK        (S_CLK),
      .PRESETn_SYNC (PRESETn_SYNC),
      .req          ({INT_Request, APB_Request}),
      .advance      (advance_s),
      .granted      (winner_r),
      .winner       (arb_win_s)
   );

   assign win_req_s = (winner_r == REQ_INT) ? INT_Request : APB_Request;

   // State, winner and handshake pulses registered together so grant/ACK have no path from a request.
   always_ff @(posedge S_CLK or negedge PRESETn_SYNC) begin
      if (!PRESETn_SYNC) begin
         state_r     <= IDLE;
         winner_r    <= REQ_APB;
         apb_grant_r <= 1'b0;
         int_grant_r <= 1'b0;
         apb_ack_r   <= 1'b0;
         int_ack_r   <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         winner_r    <= winner_nxt_s;
         apb_grant_r <= apb_grant_nxt_s;
         int_grant_r <= int_grant_nxt_s;
         apb_ack_r   <= apb_ack_nxt_s;
         int_ack_r   <= int_ack_nxt_s;
      end
   end

   // Next-state logic and next values of the registered handshake outputs.
   always_comb begin
      state_nxt_s     = state_r;
      winner_nxt_s    = winner_r;
      apb_grant_nxt_s = 1'b0;
      int_grant_nxt_s = 1'b0;
      apb_ack_nxt_s   = 1'b0;
      int_ack_nxt_s   = 1'b0;
      capture_s       = 1'b0;
      advance_s       = 1'b0;
      execute_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (arb_win_s != 2'b00) begin
               state_nxt_s     = GRANT;
               winner_nxt_s    = arb_win_s[1] ? REQ_INT : REQ_APB;
               apb_grant_nxt_s = arb_win_s[0];
               int_grant_nxt_s = arb_win_s[1];
            end else begin
               state_nxt_s = IDLE;
            end
         end
         GRANT: begin
            // A request withdrawn during its grant cycle is abandoned without moving priority.
            if (win_req_s) begin
               capture_s   = 1'b1;
               advance_s   = 1'b1;
               state_nxt_s = ACCESS;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCESS: begin
            execute_s     = 1'b1;
            apb_ack_nxt_s = (winner_r == REQ_APB);
            int_ack_nxt_s = (winner_r == REQ_INT);
            state_nxt_s   = ACK;
         end
         ACK: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Transaction capture on the closing edge of the grant cycle.
   always_ff @(posedge S_CLK or negedge PRESETn_SYNC) begin
      if (!PRESETn_SYNC) begin
         cap_addr_r <= '0;
         cap_data_r <= '0;
         cap_strb_r <= 4'b0000;
         cap_inj_r  <= 1'b0;
      end else if (capture_s) begin
         cap_addr_r <= (winner_r == REQ_INT) ? INT_ADDR : APB_OADDR;
         cap_data_r <= (winner_r == REQ_INT) ? INT_DATA : APB_ODATA;
         cap_strb_r <= (winner_r == REQ_INT) ? INT_STRB : APB_OSTRB;
         cap_inj_r  <= PAR_INJ;
      end else begin
         cap_addr_r <= cap_addr_r;
         cap_data_r <= cap_data_r;
         cap_strb_r <= cap_strb_r;
         cap_inj_r  <= cap_inj_r;
      end
   end

   assign word_s     = cap_addr_r[ADDR_WD-1:2];
   assign idx_s      = word_s[IDX_WD-1:0];
   assign addr_err_s = (cap_addr_r[1:0] != 2'b00) || (32'(word_s) >= 32'(NUM_REGS));
   assign is_read_s  = (cap_strb_r == STRB_READ);
   assign is_word0_s = (idx_s == '0);
   assign rd_word_s  = mem_r[idx_s];
   assign rd_par_s   = par_r[idx_s];

   // Byte-lane merge of captured write data over the current word.
   always_comb begin
      merged_s = rd_word_s;
      for (int b = 0; b < 4; b++) begin
         if (cap_strb_r[b]) begin
            merged_s[8*b +: 8] = cap_data_r[8*b +: 8];
         end else begin
            merged_s[8*b +: 8] = rd_word_s[8*b +: 8];
         end
      end
   end

   // Access decode: address errors suppress everything, word 0 is the read-only ID.
   always_comb begin
      data_nxt_s = '0;
      aer_nxt_s  = 1'b0;
      per_nxt_s  = 1'b0;
      wr_en_s    = 1'b0;
      if (addr_err_s) begin
         aer_nxt_s = 1'b1;
      end else if (is_read_s) begin
         if (is_word0_s) begin
            data_nxt_s = CFG_ID;
         end else begin
            data_nxt_s = rd_word_s;
            per_nxt_s  = even_parity(rd_word_s) ^ rd_par_s;
         end
      end else begin
         wr_en_s = !is_word0_s;
      end
   end

   // Register file write port; parity stored with optional injected inversion.
   always_ff @(posedge S_CLK or negedge PRESETn_SYNC) begin
      if (!PRESETn_SYNC) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_r[i] <= '0;
         end
         par_r <= '0;
      end else if (execute_s && wr_en_s) begin
         mem_r[idx_s] <= merged_s;
         par_r[idx_s] <= even_parity(merged_s) ^ cap_inj_r;
      end
   end

   // Read data and error flags load on entry to ACK and hold until the next ACK.
   always_ff @(posedge S_CLK or negedge PRESETn_SYNC) begin
      if (!PRESETn_SYNC) begin
         data_r    <= '0;
         addr_er_r <= 1'b0;
         par_er_r  <= 1'b0;
      end else if (execute_s) begin
         data_r    <= data_nxt_s;
         addr_er_r <= aer_nxt_s;
         par_er_r  <= per_nxt_s;
      end else begin
         data_r    <= data_r;
         addr_er_r <= addr_er_r;
         par_er_r  <= par_er_r;
      end
   end

   assign APB_Grant       = apb_grant_r;
   assign INT_Grant       = int_grant_r;
   assign ConfigSp_ACKAPB = apb_ack_r;
   assign INT_ACK         = int_ack_r;
   assign ConfigSp_DATA   = data_r;
   assign Addr_ER         = addr_er_r;
   assign Parity_ER       = par_er_r;

endmodule

// File: tb/tb_cfg_space_ctrl.sv
// Bench for cfg_space_ctrl: table-driven single accesses, contention pairs,
// abandoned grant and mid-transaction reset, with an ACK-side scoreboard.
module tb_cfg_space_ctrl;

   localparam logic [31:0] CFG_ID_EXP = 32'h0A9B_0001;

   logic        S_CLK = 1'b0;
   logic        PRESETn_SYNC;
   logic        APB_Request;
   logic [15:0] APB_OADDR;
   logic [31:0] APB_ODATA;
   logic [3:0]  APB_OSTRB;
   logic        APB_Grant;
   logic        ConfigSp_ACKAPB;
   logic        INT_Request;
   logic [15:0] INT_ADDR;
   logic [31:0] INT_DATA;
   logic [3:0]  INT_STRB;
   logic        INT_Grant;
   logic        INT_ACK;
   logic [31:0] ConfigSp_DATA;
   logic        Addr_ER;
   logic        Parity_ER;
   logic        PAR_INJ;

   cfg_space_ctrl dut (
      .S_CLK           (S_CLK),
      .PRESETn_SYNC    (PRESETn_SYNC),
      .APB_Request     (APB_Request),
      .APB_OADDR       (APB_OADDR),
      .APB_ODATA       (APB_ODATA),
      .APB_OSTRB       (APB_OSTRB),
      .APB_Grant       (APB_Grant),
      .ConfigSp_ACKAPB (ConfigSp_ACKAPB),
      .INT_Request     (INT_Request),
      .INT_ADDR        (INT_ADDR),
      .INT_DATA        (INT_DATA),
      .INT_STRB        (INT_STRB),
      .INT_Grant       (INT_Grant),
      .INT_ACK         (INT_ACK),
      .ConfigSp_DATA   (ConfigSp_DATA),
      .Addr_ER         (Addr_ER),
      .Parity_ER       (Parity_ER),
      .PAR_INJ         (PAR_INJ)
   );

   always #5 S_CLK = ~S_CLK;

   typedef struct {
      bit          side;      // 0 = APB, 1 = internal
      logic [15:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      bit          inj;
      logic [31:0] exp_data;
      bit          exp_aer;
      bit          exp_per;
   } vec_t;

   typedef struct {
      bit          side;
      bit          chk_rd;
      logic [31:0] data;
      bit          aer;
      bit          per;
   } exp_t;

   vec_t tbl [19];
   exp_t sb_q [$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_miss = 0;
   int   n_ack = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit side, input logic [15:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input bit inj, input logic [31:0] ed,
                               input bit ea, input bit ep);
      vec_t v;
      v.side = side; v.addr = addr; v.data = data; v.strb = strb; v.inj = inj;
      v.exp_data = ed; v.exp_aer = ea; v.exp_per = ep;
      return v;
   endfunction

   function automatic exp_t to_exp(input vec_t v);
      exp_t e;
      e.side   = v.side;
      e.chk_rd = (v.strb == 4'b0000) || v.exp_aer;
      e.data   = v.exp_data;
      e.aer    = v.exp_aer;
      e.per    = v.exp_per;
      return e;
   endfunction

   // Scoreboard: every ACK pops the oldest expectation; grants/ACKs must never overlap.
   always @(negedge S_CLK) begin
      if (APB_Grant || INT_Grant)
         chk("grant_overlap", {31'd0, APB_Grant & INT_Grant}, 32'd0);
      if (ConfigSp_ACKAPB || INT_ACK) begin
         n_ack++;
         chk("ack_overlap", {31'd0, ConfigSp_ACKAPB & INT_ACK}, 32'd0);
         chk("ack_expected", {31'd0, sb_q.size() > 0}, 32'd1);
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("ack_side", {31'd0, INT_ACK}, {31'd0, mon_e.side});
            chk("ack_addr_er", {31'd0, Addr_ER}, {31'd0, mon_e.aer});
            if (mon_e.chk_rd) begin
               chk("ack_data", ConfigSp_DATA, mon_e.data);
               chk("ack_parity_er", {31'd0, Parity_ER}, {31'd0, mon_e.per});
            end
         end
      end
   end

   // Drives one requester from posedge+1, checks grant and ACK latency. Returns at the ACK negedge.
   task automatic run_side(input bit side, input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit inj, input int exp_gnt);
      int cnt;
      if (side) begin
         INT_ADDR = addr; INT_DATA = data; INT_STRB = strb; INT_Request = 1'b1;
      end else begin
         APB_OADDR = addr; APB_ODATA = data; APB_OSTRB = strb; APB_Request = 1'b1;
      end
      PAR_INJ = inj;
      cnt = 0;
      do begin
         @(negedge S_CLK);
         cnt++;
      end while (!(side ? INT_Grant : APB_Grant) && cnt < 40);
      chk(side ? "int_grant_latency" : "apb_grant_latency", cnt, exp_gnt);
      @(posedge S_CLK);
      #1;
      if (side) INT_Request = 1'b0;
      else      APB_Request = 1'b0;
      PAR_INJ = 1'b0;
      cnt = 0;
      do begin
         @(negedge S_CLK);
         cnt++;
      end while (!(side ? INT_ACK : ConfigSp_ACKAPB) && cnt < 40);
      chk(side ? "int_ack_latency" : "apb_ack_latency", cnt, 2);
   endtask

   // Single access, then confirms the error flag still holds in the following idle cycle.
   task automatic access(input vec_t v);
      sb_q.push_back(to_exp(v));
      run_side(v.side, v.addr, v.data, v.strb, v.inj, 2);
      @(negedge S_CLK);
      chk("addr_er_hold", {31'd0, Addr_ER}, {31'd0, v.exp_aer});
      @(posedge S_CLK);
      #1;
   endtask

   // Both requesters raised on the same cycle; the loser waits for the winner's ACK plus idle.
   task automatic pair(input vec_t a, input vec_t b, input bit apb_first);
      if (apb_first) begin
         sb_q.push_back(to_exp(a)); sb_q.push_back(to_exp(b));
      end else begin
         sb_q.push_back(to_exp(b)); sb_q.push_back(to_exp(a));
      end
      fork
         run_side(1'b0, a.addr, a.data, a.strb, 1'b0, apb_first ? 2 : 6);
         run_side(1'b1, b.addr, b.data, b.strb, 1'b0, apb_first ? 6 : 2);
      join
      @(posedge S_CLK);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_apb_grant"}, {31'd0, APB_Grant}, 32'd0);
      chk({tag, "_int_grant"}, {31'd0, INT_Grant}, 32'd0);
      chk({tag, "_apb_ack"}, {31'd0, ConfigSp_ACKAPB}, 32'd0);
      chk({tag, "_int_ack"}, {31'd0, INT_ACK}, 32'd0);
      chk({tag, "_data"}, ConfigSp_DATA, 32'd0);
      chk({tag, "_addr_er"}, {31'd0, Addr_ER}, 32'd0);
      chk({tag, "_parity_er"}, {31'd0, Parity_ER}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      int cnt;
      tbl[0]  = mk(1'b0, 16'h0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
      tbl[1]  = mk(1'b0, 16'h0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      tbl[2]  = mk(1'b1, 16'h0020, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
      tbl[3]  = mk(1'b0, 16'h0020, 32'h0000_00AA, 4'h1, 1'b0, 32'h0, 1'b0, 1'b0);
      tbl[4]  = mk(1'b1, 16'h0020, 32'h0,         4'h0, 1'b0, 32'h1122_33AA, 1'b0, 1'b0);
      tbl[5]  = mk(1'b0, 16'h0102, 32'h0,         4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      tbl[6]  = mk(1'b0, 16'h0100, 32'h0,         4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      tbl[7]  = mk(1'b0, 16'h0008, 32'h0,         4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
      tbl[8]  = mk(1'b0, 16'h0008, 32'h0,         4'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      tbl[9]  = mk(1'b0, 16'h0000, 32'h0,         4'h0, 1'b0, CFG_ID_EXP, 1'b0, 1'b0);
      tbl[10] = mk(1'b0, 16'h0000, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
      tbl[11] = mk(1'b1, 16'h0000, 32'h0,         4'h0, 1'b0, CFG_ID_EXP, 1'b0, 1'b0);
      tbl[12] = mk(1'b1, 16'h00FC, 32'h1234_5678, 4'hA, 1'b0, 32'h0, 1'b0, 1'b0);
      tbl[13] = mk(1'b1, 16'h00FC, 32'h0,         4'h0, 1'b0, 32'h1200_5600, 1'b0, 1'b0);
      tbl[14] = mk(1'b0, 16'h0101, 32'h5555_AAAA, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
      tbl[15] = mk(1'b0, 16'h0110, 32'h0,         4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
      tbl[16] = mk(1'b0, 16'h0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      tbl[17] = mk(1'b0, 16'h0008, 32'h0000_0001, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
      tbl[18] = mk(1'b1, 16'h0008, 32'h0,         4'h0, 1'b0, 32'h0000_0001, 1'b0, 1'b0);

      PRESETn_SYNC = 1'b0;
      APB_Request = 1'b0; APB_OADDR = 16'h0; APB_ODATA = 32'h0; APB_OSTRB = 4'h0;
      INT_Request = 1'b0; INT_ADDR = 16'h0;  INT_DATA = 32'h0;  INT_STRB = 4'h0;
      PAR_INJ = 1'b0;
      repeat (3) @(negedge S_CLK);
      chk_reset_outputs("reset");
      PRESETn_SYNC = 1'b1;
      @(posedge S_CLK);
      #1;

      for (int i = 0; i < 19; i++) access(tbl[i]);

      // Last table access was internal, so APB holds priority for the first pair.
      pair(mk(1'b0, 16'h0020, 32'h0, 4'h0, 1'b0, 32'h1122_33AA, 1'b0, 1'b0),
           mk(1'b1, 16'h00FC, 32'h0, 4'h0, 1'b0, 32'h1200_5600, 1'b0, 1'b0), 1'b1);
      // APB write completes before the internal read of the same word.
      pair(mk(1'b0, 16'h0040, 32'h0F0F_0F0F, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0),
           mk(1'b1, 16'h0040, 32'h0, 4'h0, 1'b0, 32'h0F0F_0F0F, 1'b0, 1'b0), 1'b1);
      // A lone APB grant hands priority to the internal side.
      access(mk(1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, CFG_ID_EXP, 1'b0, 1'b0));
      pair(mk(1'b0, 16'h0102, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0),
           mk(1'b1, 16'h0040, 32'h0, 4'h0, 1'b0, 32'h0F0F_0F0F, 1'b0, 1'b0), 1'b0);

      // APB request withdrawn during its grant cycle: no ACK, priority stays internal.
      a0 = n_ack;
      APB_OADDR = 16'h0010; APB_OSTRB = 4'h0; APB_Request = 1'b1;
      cnt = 0;
      do begin
         @(negedge S_CLK);
         cnt++;
      end while (!APB_Grant && cnt < 40);
      chk("drop_grant_latency", cnt, 2);
      APB_Request = 1'b0;
      repeat (4) @(negedge S_CLK);
      chk("drop_no_ack", n_ack, a0);
      @(posedge S_CLK);
      #1;
      pair(mk(1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0),
           mk(1'b1, 16'h0008, 32'h0, 4'h0, 1'b0, 32'h0000_0001, 1'b0, 1'b0), 1'b0);

      // Reset asserted during the ACCESS cycle of a write.
      a0 = n_ack;
      APB_OADDR = 16'h0030; APB_ODATA = 32'hCAFE_F00D; APB_OSTRB = 4'hF; APB_Request = 1'b1;
      cnt = 0;
      do begin
         @(negedge S_CLK);
         cnt++;
      end while (!APB_Grant && cnt < 40);
      chk("rst_write_grant_latency", cnt, 2);
      @(posedge S_CLK);
      #1;
      APB_Request = 1'b0;
      PRESETn_SYNC = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      repeat (3) @(negedge S_CLK);
      chk("midreset_no_ack", n_ack, a0);
      PRESETn_SYNC = 1'b1;
      @(posedge S_CLK);
      #1;
      pair(mk(1'b0, 16'h0030, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0),
           mk(1'b1, 16'h0000, 32'h0, 4'h0, 1'b0, CFG_ID_EXP, 1'b0, 1'b0), 1'b1);

      repeat (2) @(negedge S_CLK);
      chk("scoreboard_empty", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
